// File: rtl/dma_bus_arbiter.sv
// dma_bus_arbiter
//
// Lends the Z80 external bus to up to NREQ DMA-style requesters. It asks the
// CPU for the bus via nBUSRQ and waits for nBUSACK. It then grants one
// requester at a time in round-robin order and caps each tenure at MAX_BURST
// cycles. After every release it leaves the CPU at least MIN_GAP cycles of
// bus ownership before asking again.
//
// Ports:
//   clk        system clock (same as the CPU CLK pin)
//   reset      synchronous, active-high reset
//   req        per-requester level request, held until the requester is done
//   gnt        one-hot grant (at most one bit set)
//   gnt_id     index of the current or most recent owner
//   dma_active external bus mux select, 1 = DMA owns the bus
//   nBUSRQ     bus request to the CPU, active-low
//   nBUSACK    bus acknowledge from the CPU, active-low, synchronous to clk
//
// All outputs come straight from flops.
module dma_bus_arbiter #(
    parameter int NREQ      = 2,
    parameter int MAX_BURST = 16,
    parameter int MIN_GAP   = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [1:0]      gnt_id,
    output logic            dma_active,
    output logic            nBUSRQ,
    input  logic            nBUSACK
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_ACK = 3'd1,
        S_GRANT    = 3'd2,
        S_RELEASE  = 3'd3,
        S_GAP      = 3'd4
    } state_t;

    localparam logic [7:0] MAX_BURST_C = 8'(MAX_BURST);
    localparam logic [3:0] MIN_GAP_C   = 4'(MIN_GAP);

    state_t          state_r, state_s;
    logic [NREQ-1:0] gnt_r, gnt_s;
    logic [1:0]      gnt_id_r, gnt_id_s;
    logic            dma_active_r, dma_active_s;
    logic            nbusrq_r, nbusrq_s;
    logic [7:0]      burst_r, burst_s;
    logic [3:0]      gap_r, gap_s;
    logic [1:0]      rr_r, rr_s;

    logic            any_req_s;
    logic            owner_req_s;
    logic [1:0]      winner_s;
    logic [NREQ-1:0] winner_onehot_s;
    logic [1:0]      next_ptr_s;

    // First set request at or after ptr, wrapping modulo NREQ. Loops run
    // downward so the lowest qualifying index is the one left standing.
    function automatic logic [1:0] pick_winner(input logic [NREQ-1:0] r,
                                               input logic [1:0]      ptr);
        logic [1:0] hi_w;
        logic [1:0] lo_w;
        logic       hi_found;
        hi_w     = 2'd0;
        lo_w     = 2'd0;
        hi_found = 1'b0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (r[j] && (j >= int'(ptr))) begin
                hi_w     = 2'(j);
                hi_found = 1'b1;
            end else begin
                hi_w = hi_w;
            end
            if (r[j]) begin
                lo_w = 2'(j);
            end else begin
                lo_w = lo_w;
            end
        end
        if (hi_found) begin
            return hi_w;
        end else begin
            return lo_w;
        end
    endfunction

    // Request summary, current owner's request and the next rr pointer.
    always_comb begin
        any_req_s   = |req;
        owner_req_s = 1'b0;
        for (int j = 0; j < NREQ; j++) begin
            if (2'(j) == gnt_id_r) begin
                owner_req_s = req[j];
            end else begin
                owner_req_s = owner_req_s;
            end
        end
        if (int'(gnt_id_r) >= NREQ - 1) begin
            next_ptr_s = 2'd0;
        end else begin
            next_ptr_s = gnt_id_r + 2'd1;
        end
    end

    // Round-robin winner and its one-hot grant vector.
    always_comb begin
        winner_s        = pick_winner(req, rr_r);
        winner_onehot_s = {NREQ{1'b0}};
        for (int j = 0; j < NREQ; j++) begin
            winner_onehot_s[j] = (2'(j) == winner_s);
        end
    end

    // Next-state and next-output logic for the bus ownership FSM.
    always_comb begin
        state_s      = state_r;
        gnt_s        = gnt_r;
        gnt_id_s     = gnt_id_r;
        dma_active_s = dma_active_r;
        nbusrq_s     = nbusrq_r;
        burst_s      = burst_r;
        gap_s        = gap_r;
        rr_s         = rr_r;
        case (state_r)
            S_IDLE: begin
                if (any_req_s) begin
                    state_s  = S_WAIT_ACK;
                    nbusrq_s = 1'b0;
                end else begin
                    nbusrq_s = 1'b1;
                end
            end
            S_WAIT_ACK: begin
                if (!nBUSACK && any_req_s) begin
                    state_s      = S_GRANT;
                    gnt_s        = winner_onehot_s;
                    gnt_id_s     = winner_s;
                    dma_active_s = 1'b1;
                    burst_s      = 8'd1;
                end else if (!any_req_s && nBUSACK) begin
                    // Nobody wants the bus and the CPU never let go: back off.
                    state_s  = S_IDLE;
                    nbusrq_s = 1'b1;
                end else if (!any_req_s) begin
                    // The CPU already acked, so hand the bus back properly.
                    state_s      = S_RELEASE;
                    gnt_s        = {NREQ{1'b0}};
                    dma_active_s = 1'b0;
                    nbusrq_s     = 1'b1;
                    rr_s         = next_ptr_s;
                end else begin
                    state_s = S_WAIT_ACK;
                end
            end
            S_GRANT: begin
                if (!owner_req_s || (burst_r == MAX_BURST_C)) begin
                    // Owner finished or used its full burst; a preempted
                    // owner keeps req high and competes again later.
                    state_s      = S_RELEASE;
                    gnt_s        = {NREQ{1'b0}};
                    dma_active_s = 1'b0;
                    nbusrq_s     = 1'b1;
                    rr_s         = next_ptr_s;
                end else begin
                    burst_s = burst_r + 8'd1;
                end
            end
            S_RELEASE: begin
                if (nBUSACK) begin
                    if (MIN_GAP_C == 4'd0) begin
                        state_s = S_IDLE;
                    end else begin
                        state_s = S_GAP;
                        gap_s   = MIN_GAP_C;
                    end
                end else begin
                    state_s = S_RELEASE;
                end
            end
            S_GAP: begin
                if (gap_r <= 4'd1) begin
                    state_s = S_IDLE;
                    gap_s   = 4'd0;
                end else begin
                    gap_s = gap_r - 4'd1;
                end
            end
            default: begin
                state_s      = S_IDLE;
                gnt_s        = {NREQ{1'b0}};
                dma_active_s = 1'b0;
                nbusrq_s     = 1'b1;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= S_IDLE;
            gnt_r        <= {NREQ{1'b0}};
            gnt_id_r     <= 2'd0;
            dma_active_r <= 1'b0;
            nbusrq_r     <= 1'b1;
            burst_r      <= 8'd0;
            gap_r        <= 4'd0;
            rr_r         <= 2'd0;
        end else begin
            state_r      <= state_s;
            gnt_r        <= gnt_s;
            gnt_id_r     <= gnt_id_s;
            dma_active_r <= dma_active_s;
            nbusrq_r     <= nbusrq_s;
            burst_r      <= burst_s;
            gap_r        <= gap_s;
            rr_r         <= rr_s;
        end
    end

    assign gnt        = gnt_r;
    assign gnt_id     = gnt_id_r;
    assign dma_active = dma_active_r;
    assign nBUSRQ     = nbusrq_r;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Self-checking bench for dma_bus_arbiter.
//
// Requesters each carry a job length. A requester holds req while its job has
// cycles left and counts down on every cycle it sees its grant. A reference
// model works at the level of tenures. It hands out round-robin turns of
// min(remaining, MAX_BURST) cycles and queues the expected (owner, length)
// pairs. A monitor records each observed tenure and checks it against that
// queue. It also checks the CPU gap after each release and the bus invariants
// on every cycle.
module tb_dma_bus_arbiter;
    localparam int NREQ      = 2;
    localparam int MAX_BURST = 16;
    localparam int MIN_GAP   = 4;

    logic            clk;
    logic            reset;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic [1:0]      gnt_id;
    logic            dma_active;
    logic            nBUSRQ;
    logic            nBUSACK;

    int checks   = 0;
    int failures = 0;

    bit job_mode = 1'b0;
    bit mon_en   = 1'b0;
    int cpu_mode = 0;      // 0 auto CPU with random latency, 1 never acks, 2 driven by hand
    int cpu_dly  = 0;
    int rem[NREQ];
    int model_rr = 0;
    int exp_id_q[$];
    int exp_len_q[$];

    dma_bus_arbiter #(.NREQ(NREQ), .MAX_BURST(MAX_BURST), .MIN_GAP(MIN_GAP)) dut (
        .clk(clk), .reset(reset), .req(req), .gnt(gnt), .gnt_id(gnt_id),
        .dma_active(dma_active), .nBUSRQ(nBUSRQ), .nBUSACK(nBUSACK)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Absolute time limit so the run cannot hang.
    initial begin
        #600000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic bit pending();
        bit p = 1'b0;
        for (int i = 0; i < NREQ; i++) if (rem[i] > 0) p = 1'b1;
        return p;
    endfunction

    // Tenure-level model: round-robin turns of at most MAX_BURST cycles.
    task automatic model_round(input int j0, input int j1);
        int r[NREQ];
        int id;
        int len;
        r[0] = j0;
        r[1] = j1;
        forever begin
            id = -1;
            for (int k = 0; k < NREQ; k++) begin
                if (id < 0 && r[(model_rr + k) % NREQ] > 0) id = (model_rr + k) % NREQ;
            end
            if (id < 0) break;
            len = (r[id] < MAX_BURST) ? r[id] : MAX_BURST;
            exp_id_q.push_back(id);
            exp_len_q.push_back(len);
            r[id] -= len;
            model_rr = (id + 1) % NREQ;
        end
    endtask

    // One cycle of stimulus at the falling edge: requesters, then the CPU.
    task automatic tick();
        @(negedge clk);
        if (job_mode) begin
            for (int i = 0; i < NREQ; i++) begin
                if (gnt[i] && rem[i] > 0) rem[i]--;
                req[i] = (rem[i] != 0);
            end
        end
        if (cpu_mode == 0) begin
            if (nBUSACK != nBUSRQ) begin
                if (cpu_dly == 0) begin
                    nBUSACK = nBUSRQ;
                    cpu_dly = $urandom_range(0, 3);
                end else begin
                    cpu_dly--;
                end
            end
        end else if (cpu_mode == 1) begin
            nBUSACK = 1'b1;
        end
    endtask

    task automatic run_round(input int j0, input int j1);
        bit done = 1'b0;
        model_round(j0, j1);
        tick();
        rem[0] = j0;
        rem[1] = j1;
        for (int i = 0; i < NREQ; i++) req[i] = (rem[i] != 0);
        for (int t = 0; t < 3000 && !done; t++) begin
            tick();
            done = (exp_len_q.size() == 0) && !pending() && nBUSRQ && nBUSACK && !dma_active;
        end
        check("round_complete", int'(done), 1);
        exp_id_q.delete();
        exp_len_q.delete();
        for (int i = 0; i < NREQ; i++) rem[i] = 0;
        repeat (MIN_GAP + 3) tick();
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_grant(input string name);
        bit seen = 1'b0;
        for (int t = 0; t < 100 && !seen; t++) begin
            tick();
            seen = (gnt != '0);
        end
        check(name, int'(seen), 1);
    endtask

    // Monitor: invariants every cycle, tenure scoreboard and CPU gap checks.
    initial begin
        int cur_len = 0;
        int cur_id  = 0;
        int gapcnt  = 0;
        int e_id;
        int e_len;
        bit after_rel = 1'b0;
        bit gap_chk   = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            check("gnt_onehot0", int'($onehot0(gnt)), 1);
            check("dma_eq_or_gnt", int'(dma_active), int'(|gnt));
            if (gnt != '0) begin
                check("gnt_needs_ack", int'(nBUSACK), 0);
                check("gnt_matches_id", int'(gnt), 1 << gnt_id);
                check("busrq_low_in_grant", int'(nBUSRQ), 0);
            end
            if (!mon_en || reset) begin
                cur_len   = 0;
                gapcnt    = 0;
                after_rel = 1'b0;
                gap_chk   = 1'b0;
            end else if (gnt != '0) begin
                if (cur_len == 0) cur_id = gnt_id;
                cur_len++;
                after_rel = 1'b1;
                gapcnt    = 0;
            end else begin
                if (cur_len != 0) begin
                    if (exp_len_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_tenure actual=owner%0d_len%0d required=none", cur_id, cur_len);
                    end else begin
                        e_id  = exp_id_q.pop_front();
                        e_len = exp_len_q.pop_front();
                        check("tenure_owner", cur_id, e_id);
                        check("tenure_len", cur_len, e_len);
                    end
                    cur_len = 0;
                end
                if (nBUSRQ && nBUSACK) begin
                    if (gapcnt == 0) gap_chk = after_rel && pending();
                    gapcnt++;
                end else if (!nBUSRQ && gapcnt != 0) begin
                    if (gap_chk) check("cpu_gap", gapcnt, MIN_GAP + 1);
                    gapcnt    = 0;
                    after_rel = 1'b0;
                    gap_chk   = 1'b0;
                end
            end
        end
    end

    // Main stimulus sequence.
    initial begin
        req     = '0;
        nBUSACK = 1'b1;
        reset   = 1'b1;
        for (int i = 0; i < NREQ; i++) rem[i] = 0;
        tick();
        tick();
        check("rst_gnt", int'(gnt), 0);
        check("rst_gnt_id", int'(gnt_id), 0);
        check("rst_dma_active", int'(dma_active), 0);
        check("rst_nbusrq", int'(nBUSRQ), 1);
        reset = 1'b0;
        tick();

        // Scoreboarded job rounds: single, round-robin, preemption, random.
        job_mode = 1'b1;
        mon_en   = 1'b1;
        run_round(5, 0);
        run_round(48, 48);
        run_round(40, 0);
        run_round(0, 3);
        for (int n = 0; n < 12; n++) run_round($urandom_range(0, 40), $urandom_range(0, 40));

        // Unconstrained request toggling, invariants only.
        mon_en   = 1'b0;
        job_mode = 1'b0;
        for (int n = 0; n < 400; n++) begin
            tick();
            req = NREQ'($urandom);
        end
        req = '0;
        repeat (20) tick();

        // Request pulse that the CPU never acknowledges.
        pulse_reset();
        cpu_mode = 1;
        tick();
        req = 2'b01;
        tick();
        req = 2'b00;
        check("abandon_busrq_low", int'(nBUSRQ), 0);
        tick();
        check("abandon_busrq_high", int'(nBUSRQ), 1);
        for (int n = 0; n < 4; n++) begin
            tick();
            check("abandon_no_gnt", int'(gnt), 0);
        end

        // CPU acks in the same cycle the request drops: release, never grant.
        cpu_mode = 2;
        nBUSACK  = 1'b1;
        tick();
        req = 2'b01;
        tick();
        check("ackdrop_busrq_low", int'(nBUSRQ), 0);
        req     = 2'b00;
        nBUSACK = 1'b0;
        tick();
        check("ackdrop_busrq_high", int'(nBUSRQ), 1);
        check("ackdrop_no_gnt", int'(gnt), 0);
        check("ackdrop_dma", int'(dma_active), 0);
        req = 2'b01;
        tick();
        check("ackdrop_release_holds", int'(nBUSRQ), 1);
        req     = 2'b00;
        nBUSACK = 1'b1;
        for (int n = 0; n < MIN_GAP + 3; n++) begin
            tick();
            check("ackdrop_idle_busrq", int'(nBUSRQ), 1);
        end

        // Reset in the middle of a grant returns the rr pointer to 0.
        cpu_mode = 0;
        pulse_reset();
        req = 2'b01;
        wait_grant("rr_first_grant_seen");
        check("rr_first_grant", int'(gnt), 1);
        req = 2'b00;
        repeat (MIN_GAP + 12) tick();
        req = 2'b11;
        wait_grant("rr_second_grant_seen");
        check("rr_after_release", int'(gnt), 2);
        tick();
        reset = 1'b1;
        tick();
        check("midrst_gnt", int'(gnt), 0);
        check("midrst_dma", int'(dma_active), 0);
        check("midrst_nbusrq", int'(nBUSRQ), 1);
        check("midrst_gnt_id", int'(gnt_id), 0);
        reset = 1'b0;
        wait_grant("rr_reset_grant_seen");
        check("rr_after_reset", int'(gnt), 1);
        req = 2'b00;
        repeat (MIN_GAP + 12) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
